// File: rtl/clkgen_pkg.sv
// rtl/clkgen_pkg.sv - shared types and sizing helpers for the clock-generation sequencer
// Purpose: sequencer state encoding plus constant functions used to size its counters.
// Ports: none (package).
package clkgen_pkg;

    typedef enum logic [2:0] {
        RESET     = 3'd0,
        WAIT_LOCK = 3'd1,
        RUN       = 3'd2,
        SW_PRE    = 3'd3,
        SW_POST   = 3'd4,
        FAIL      = 3'd5
    } state_t;

    // Bits needed to hold values 0..value-1 (never less than 1).
    function automatic int clog2(input int value);
        int width;
        width = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) width = i + 1;
        end
        return width;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/clkgen_sequencer_lock_sync.sv
// rtl/clkgen_sequencer_lock_sync.sv - two-flop synchroniser for the DCM lock inputs
// Purpose: brings asynchronous LOCKED bits into the clk48 domain.
// Ports: clk (sync clock), rst (sync active-high), d (async bits), q (synchronised bits).
module lock_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/clkgen_sequencer.sv
// rtl/clkgen_sequencer.sv - DCM reset/lock/retry sequencer with quiesced clock-select switching
// Purpose: resets the DCM tree, waits for stable lock with timeout and bounded retry, restarts
//          on lock loss, and performs request-driven fast-clock mux changes with quiet periods.
// Ports: clk48/rst (clock, sync active-high reset); locked_in (raw DCM LOCKED);
//        sel_req/sel_req_valid (source request strobe); dcm_rst (DCM reset); clksel (mux select);
//        sel_busy (switch in progress); clocks_locked, lock_fail, relock_count (status).
module clkgen_sequencer
    import clkgen_pkg::*;
#(
    parameter int N_DCM         = 4,
    parameter int N_SEL         = 2,
    parameter int SEL_W         = 1,
    parameter int RST_CYCLES    = 4,
    parameter int STABLE_CYCLES = 16,
    parameter int LOCK_TIMEOUT  = 4800,
    parameter int MAX_RETRY     = 3,
    parameter int QUIESCE       = 8
) (
    input  logic             clk48,
    input  logic             rst,
    input  logic [N_DCM-1:0] locked_in,
    input  logic [SEL_W-1:0] sel_req,
    input  logic             sel_req_valid,
    output logic             dcm_rst,
    output logic [SEL_W-1:0] clksel,
    output logic             sel_busy,
    output logic             clocks_locked,
    output logic             lock_fail,
    output logic [7:0]       relock_count
);

    localparam int CNT_W = clog2(max3(RST_CYCLES, LOCK_TIMEOUT, QUIESCE) + 1);
    localparam int STB_W = clog2(STABLE_CYCLES + 1);
    localparam int RTY_W = clog2(MAX_RETRY + 1);
    localparam logic [SEL_W:0] SEL_LIMIT = (SEL_W + 1)'(N_SEL);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STB_W-1:0]   stable_q, stable_d;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic [SEL_W-1:0]   target_q, target_d;
    logic               pend_valid_q, pend_valid_d;
    logic [SEL_W-1:0]   pend_sel_q, pend_sel_d;
    logic [SEL_W-1:0]   clksel_d;
    logic [7:0]         relock_d;
    logic               dcm_rst_d, sel_busy_d, clocks_locked_d, lock_fail_d;
    logic [N_DCM-1:0]   locked_sync;
    logic               all_lk;
    logic [SEL_W-1:0]   ref_sel;
    logic               req_ok;
    logic               consumed;

    lock_sync #(.WIDTH(N_DCM)) u_lock_sync (
        .clk (clk48),
        .rst (rst),
        .d   (locked_in),
        .q   (locked_sync)
    );

    assign all_lk = &locked_sync;

    // While a switch is in flight the select it will end on is the one a request must differ from.
    assign ref_sel = (state_q == SW_PRE || state_q == SW_POST) ? target_q : clksel;
    assign req_ok  = sel_req_valid && ({1'b0, sel_req} < SEL_LIMIT) && (sel_req != ref_sel);

    always_ff @(posedge clk48) begin
        if (rst) begin
            state_q       <= RESET;
            cnt_q         <= '0;
            stable_q      <= '0;
            retry_q       <= '0;
            target_q      <= '0;
            pend_valid_q  <= 1'b0;
            pend_sel_q    <= '0;
            clksel        <= '0;
            relock_count  <= '0;
            dcm_rst       <= 1'b1;
            sel_busy      <= 1'b0;
            clocks_locked <= 1'b0;
            lock_fail     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stable_q      <= stable_d;
            retry_q       <= retry_d;
            target_q      <= target_d;
            pend_valid_q  <= pend_valid_d;
            pend_sel_q    <= pend_sel_d;
            clksel        <= clksel_d;
            relock_count  <= relock_d;
            dcm_rst       <= dcm_rst_d;
            sel_busy      <= sel_busy_d;
            clocks_locked <= clocks_locked_d;
            lock_fail     <= lock_fail_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        stable_d     = stable_q;
        retry_d      = retry_q;
        target_d     = target_q;
        pend_valid_d = pend_valid_q;
        pend_sel_d   = pend_sel_q;
        clksel_d     = clksel;
        relock_d     = relock_count;
        consumed     = 1'b0;
        case (state_q)
            RESET: begin
                if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                    state_d  = WAIT_LOCK;
                    cnt_d    = '0;
                    stable_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_LOCK: begin
                // The last stable cycle and the timeout cycle can coincide; lock wins.
                if (all_lk && stable_q == STB_W'(STABLE_CYCLES - 1)) begin
                    state_d = RUN;
                    retry_d = '0;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    cnt_d   = '0;
                    retry_d = retry_q + RTY_W'(1);
                    state_d = (retry_q == RTY_W'(MAX_RETRY - 1)) ? FAIL : RESET;
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
                    stable_d = all_lk ? stable_q + STB_W'(1) : '0;
                end
            end
            RUN: begin
                if (!all_lk) begin
                    state_d  = RESET;
                    cnt_d    = '0;
                    retry_d  = '0;
                    relock_d = (relock_count == 8'hFF) ? relock_count : relock_count + 8'd1;
                end else if (req_ok) begin
                    // A fresh request is newer than anything pending, so it supersedes it.
                    state_d      = SW_PRE;
                    cnt_d        = '0;
                    target_d     = sel_req;
                    pend_valid_d = 1'b0;
                    consumed     = 1'b1;
                end else if (pend_valid_q) begin
                    // A pending index can equal clksel after an abort late in SW_POST; drop it.
                    pend_valid_d = 1'b0;
                    if (pend_sel_q != clksel) begin
                        state_d  = SW_PRE;
                        cnt_d    = '0;
                        target_d = pend_sel_q;
                    end
                end
            end
            SW_PRE, SW_POST: begin
                if (!all_lk) begin
                    state_d      = RESET;
                    cnt_d        = '0;
                    retry_d      = '0;
                    pend_valid_d = 1'b1;
                    pend_sel_d   = target_q;
                end else if (cnt_q == CNT_W'(QUIESCE - 1)) begin
                    cnt_d = '0;
                    if (state_q == SW_PRE) begin
                        clksel_d = target_q;
                        state_d  = SW_POST;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
        // Requests not acted on this cycle are parked; a same-cycle request beats an abort re-store.
        if (req_ok && !consumed) begin
            pend_valid_d = 1'b1;
            pend_sel_d   = sel_req;
        end
    end

    always_comb begin
        dcm_rst_d       = (state_d == RESET);
        sel_busy_d      = (state_d == SW_PRE) || (state_d == SW_POST);
        clocks_locked_d = (state_d == RUN) || (state_d == SW_PRE) || (state_d == SW_POST);
        lock_fail_d     = (state_d == FAIL);
    end

endmodule
